// File: rtl/inst_fetch_buf.sv
// Instruction-fetch front end. Owns the fetch PC, requests words from the
// instruction ROM over a ce/ack handshake, and queues the returned words in an
// in-order FIFO. Decode sees the FIFO head plus a valid flag. An empty FIFO
// presents a NOP (all zeros) with PC 0. Branch or exception redirects clear
// the queue and reload the fetch PC.
module inst_fetch_buf #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,   // power of 2, 2..16
  parameter int          CNT_W    = 3    // 2**CNT_W > DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [31:0]      new_pc_i,
  output logic             rom_ce_o,
  output logic [31:0]      rom_addr_o,
  input  logic             rom_ack_i,
  input  logic [31:0]      rom_data_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      inst_o,
  output logic             inst_valid_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Architectural fetch state and FIFO bookkeeping.
  logic [31:0]      fetch_pc;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // FIFO payload: PC and instruction word of each fetched entry.
  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Redirect targets are word addresses; the low two bits are dropped.
  logic unused_new_pc_lsbs;
  assign unused_new_pc_lsbs = ^new_pc_i[1:0];

  // Handshake and FIFO control decode.
  always_comb begin
    full     = (count == CNT_W'(DEPTH));
    empty    = (count == '0);
    // Requests are withheld during reset and flush so an ack in those
    // cycles can never push a stale word.
    rom_ce_o = !rst && !flush_i && !full;
    push     = rom_ce_o && rom_ack_i;
    pop      = !empty && !stall_i;
  end

  assign rom_addr_o = fetch_pc;
  assign count_o    = count;

  // Fetch PC, pointers and occupancy; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (flush_i) begin
      fetch_pc <= {new_pc_i[31:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        fetch_pc <= fetch_pc + 32'd4;  // wraps naturally past 32'hFFFF_FFFC
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO write port; push is already suppressed during reset and flush.
  always_ff @(posedge clk) begin
    // NOTE: the storage arrays are deliberately not reset; the outputs are
    // masked by the empty flag, so stale contents are never visible.
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      inst_mem[wr_ptr] <= rom_data_i;
    end
  end

  // Head presentation to decode; an empty FIFO shows a NOP at PC 0.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    pc_o         = 32'h0;
    inst_o       = 32'h0;
    inst_valid_o = !empty;
    if (!empty) begin
      pc_o   = pc_mem[rd_ptr];
      inst_o = inst_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Self-checking bench for inst_fetch_buf. A queue-based reference model tracks
// the fetch PC and the list of fetched {pc, inst} entries; directed scenarios
// and a randomized run compare the DUT against it.
module tb_inst_fetch_buf;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;
  localparam int          CNT_W    = 3;
  localparam int          VW       = 1 + 32 + 1 + 32 + 32 + CNT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall_i;
  logic             flush_i;
  logic [31:0]      new_pc_i;
  logic             rom_ce_o;
  logic [31:0]      rom_addr_o;
  logic             rom_ack_i;
  logic [31:0]      rom_data_i;
  logic [31:0]      pc_o;
  logic [31:0]      inst_o;
  logic             inst_valid_o;
  logic [CNT_W-1:0] count_o;

  int checks = 0;
  int errors = 0;

  inst_fetch_buf #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .new_pc_i     (new_pc_i),
    .rom_ce_o     (rom_ce_o),
    .rom_addr_o   (rom_addr_o),
    .rom_ack_i    (rom_ack_i),
    .rom_data_i   (rom_data_i),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;

  function automatic logic exp_ce();
    return !rst && !flush_i && (q.size() != DEPTH);
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [31:0] p;
    logic [31:0] i;
    p = (q.size() != 0) ? q[0].pc   : 32'h0;
    i = (q.size() != 0) ? q[0].inst : 32'h0;
    return {exp_ce(), m_pc, q.size() != 0, p, i, CNT_W'(q.size())};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {rom_ce_o, rom_addr_o, inst_valid_o, pc_o, inst_o, count_o};
  endfunction

  // One clock edge: advance the model with the inputs presented this cycle,
  // then return at the falling edge where new inputs are driven.
  task automatic tick();
    logic ce;
    ce = exp_ce();
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_pc = RESET_PC;
    end else if (flush_i) begin
      q.delete();
      m_pc = {new_pc_i[31:2], 2'b00};
    end else begin
      if (q.size() != 0 && !stall_i) void'(q.pop_front());
      if (ce && rom_ack_i) begin
        q.push_back('{pc: m_pc, inst: rom_data_i});
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_flush(input logic [31:0] target);
    flush_i  = 1'b1;
    new_pc_i = target;
    tick();
    flush_i  = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; new_pc_i = '0;
    rom_ack_i = 1'b1; rom_data_i = 32'hDEAD_BEEF;
    tick(); tick();
    #1;
    checks++;
    if (rom_ce_o !== 1'b0) begin
      errors++; $display("FAIL reset_ce: got %b want 0", rom_ce_o);
    end
    checks++;
    if ({count_o, inst_valid_o} !== {CNT_W'(0), 1'b0}) begin
      errors++; $display("FAIL reset_empty: count %0d valid %b want 0 0", count_o, inst_valid_o);
    end
    checks++;
    if ({pc_o, inst_o, rom_addr_o} !== {32'h0, 32'h0, RESET_PC}) begin
      errors++; $display("FAIL reset_outs: pc %h inst %h addr %h want 0 0 %h", pc_o, inst_o, rom_addr_o, RESET_PC);
    end
    rst = 1'b0;
  endtask

  // Zero-wait ROM returning its address as data: one instruction per cycle.
  task automatic test_stream();
    rom_ack_i = 1'b1; stall_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rom_data_i = m_pc;
      #1;
      checks++;
      if (rom_addr_o !== 32'(i * 4)) begin
        errors++; $display("FAIL stream_addr[%0d]: got %h want %h", i, rom_addr_o, 32'(i * 4));
      end
      if (i > 0) begin
        checks++;
        if ({inst_valid_o, pc_o, inst_o, count_o} !== {1'b1, 32'((i - 1) * 4), 32'((i - 1) * 4), CNT_W'(1)}) begin
          errors++; $display("FAIL stream_head[%0d]: valid %b pc %h inst %h count %0d want pc %h count 1",
                             i, inst_valid_o, pc_o, inst_o, count_o, 32'((i - 1) * 4));
        end
      end
      tick();
    end
  endtask

  // Stall until full, then drain in order.
  task automatic test_full_stall();
    do_flush(32'h0);
    stall_i = 1'b1; rom_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rom_data_i = $urandom;
      tick();
    end
    #1;
    checks++;
    if ({count_o, rom_ce_o, rom_addr_o, pc_o} !== {CNT_W'(4), 1'b0, 32'h10, 32'h0}) begin
      errors++; $display("FAIL full_state: count %0d ce %b addr %h pc %h want 4 0 00000010 0", count_o, rom_ce_o, rom_addr_o, pc_o);
    end
    stall_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rom_data_i = $urandom;
      #1;
      checks++;
      if (pc_o !== 32'(i * 4)) begin
        errors++; $display("FAIL drain_pc[%0d]: got %h want %h", i, pc_o, 32'(i * 4));
      end
      if (i < 2) begin
        checks++;
        if (rom_ce_o !== (i == 1)) begin
          errors++; $display("FAIL drain_ce[%0d]: got %b want %b", i, rom_ce_o, i == 1);
        end
      end
      tick();
    end
  endtask

  // Ack every third cycle: no duplicate or skipped PCs, valid follows acks.
  task automatic test_ack_gaps();
    do_flush(32'h200);
    stall_i = 1'b0;
    for (int i = 0; i < 15; i++) begin
      rom_ack_i  = (i % 3 == 2);
      rom_data_i = $urandom;
      #1;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL gaps[%0d]: got %h want %h", i, dut_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_flush();
    do_flush(32'h0);
    stall_i = 1'b1; rom_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rom_data_i = $urandom;
      tick();
    end
    flush_i = 1'b1; new_pc_i = 32'h0000_0103; rom_data_i = 32'h1234_5678;
    #1;
    checks++;
    if ({count_o, rom_ce_o} !== {CNT_W'(3), 1'b0}) begin
      errors++; $display("FAIL flush_pre: count %0d ce %b want 3 0", count_o, rom_ce_o);
    end
    tick();
    flush_i = 1'b0;
    #1;
    checks++;
    if ({count_o, inst_valid_o, inst_o, rom_addr_o} !== {CNT_W'(0), 1'b0, 32'h0, 32'h100}) begin
      errors++; $display("FAIL flush_post: count %0d valid %b inst %h addr %h want 0 0 0 00000100",
                         count_o, inst_valid_o, inst_o, rom_addr_o);
    end
    stall_i = 1'b0;
    tick();
    #1;
    checks++;
    if ({inst_valid_o, pc_o} !== {1'b1, 32'h100}) begin
      errors++; $display("FAIL flush_first: valid %b pc %h want 1 00000100", inst_valid_o, pc_o);
    end
    // Back-to-back flushes: the later target wins.
    flush_i = 1'b1; new_pc_i = 32'h300; tick();
    new_pc_i = 32'h404; tick();
    flush_i = 1'b0; rom_ack_i = 1'b0;
    #1;
    checks++;
    if ({rom_addr_o, count_o} !== {32'h404, CNT_W'(0)}) begin
      errors++; $display("FAIL flush_b2b: addr %h count %0d want 00000404 0", rom_addr_o, count_o);
    end
  endtask

  task automatic test_reset_mid();
    do_flush(32'h0);
    stall_i = 1'b1; rom_ack_i = 1'b1;
    tick(); tick();
    rom_ack_i = 1'b0;
    #1;
    checks++;
    if ({count_o, rom_ce_o} !== {CNT_W'(2), 1'b1}) begin
      errors++; $display("FAIL rmid_pending: count %0d ce %b want 2 1", count_o, rom_ce_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rom_ce_o !== 1'b0) begin
      errors++; $display("FAIL rmid_ce: got %b want 0", rom_ce_o);
    end
    tick();
    #1;
    checks++;
    if ({count_o, inst_valid_o, rom_addr_o} !== {CNT_W'(0), 1'b0, RESET_PC}) begin
      errors++; $display("FAIL rmid_state: count %0d valid %b addr %h want 0 0 %h", count_o, inst_valid_o, rom_addr_o, RESET_PC);
    end
    rst = 1'b0; stall_i = 1'b0; rom_ack_i = 1'b1; rom_data_i = 32'hCAFE_0001;
    tick();
    #1;
    checks++;
    if ({inst_valid_o, pc_o, inst_o} !== {1'b1, RESET_PC, 32'hCAFE_0001}) begin
      errors++; $display("FAIL rmid_restart: valid %b pc %h inst %h want 1 %h cafe0001", inst_valid_o, pc_o, inst_o, RESET_PC);
    end
  endtask

  task automatic test_pc_wrap();
    do_flush(32'hFFFF_FFFC);
    stall_i = 1'b0; rom_ack_i = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] want;
      want = 32'hFFFF_FFFC + 32'(i * 4);
      #1;
      checks++;
      if ({inst_valid_o, pc_o} !== {1'b1, want}) begin
        errors++; $display("FAIL wrap_pc[%0d]: valid %b pc %h want 1 %h", i, inst_valid_o, pc_o, want);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      flush_i    = ($urandom_range(0, 19) == 0);
      new_pc_i   = $urandom;
      stall_i    = ($urandom_range(0, 1) == 0);
      rom_ack_i  = ($urandom_range(0, 9) < 6);
      rom_data_i = $urandom;
      #1;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), exp_vec());
      end
      tick();
    end
    rst = 1'b0; flush_i = 1'b0;
  endtask

  initial begin
    m_pc = RESET_PC;
    @(negedge clk);
    test_reset();
    test_stream();
    test_full_stall();
    test_ack_gaps();
    test_flush();
    test_reset_mid();
    test_pc_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
